// File: rtl/alu_pkg.sv
// Shared opcode, status-bit and FSM definitions for the ALU arbiter slice.
// Latency helper maps an opcode to the number of cycles operands are held.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_ADDI = 4'd12;
  localparam logic [3:0] OP_ADDU = 4'd13;

  localparam int ST_ZERO   = 7;
  localparam int ST_MULOVF = 6;
  localparam int ST_CARRY  = 5;
  localparam int ST_NEG    = 4;
  localparam int ST_ALIGN  = 3;
  localparam int ST_DIV0   = 2;

  // Exception bits that accumulate into the sticky register: mulovf, carry, align, div0.
  localparam logic [7:0] STICKY_MASK = 8'h6C;

  localparam logic [3:0] CTRL_RESET = 4'd15;
  localparam int         CNT_W      = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] op_cycles(input logic [3:0] ctl,
                                                 input int mul_c,
                                                 input int div_c);
    if (ctl == OP_MUL) return CNT_W'(mul_c);
    if (ctl == OP_DIV) return CNT_W'(div_c);
    return CNT_W'(1);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin grant. On a tie the requester that did not win last
// time gets the grant; the pointer moves whenever a grant is issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_enable,
  output logic [1:0] o_grant
);

  logic r_last_grant;

  always_comb begin
    o_grant = 2'b00;
    if (i_enable) begin
      case (i_valid)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (|o_grant) begin
      r_last_grant <= o_grant[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters,
// holds operands for a per-opcode latency, and returns a registered result.
//
// Handshake: a transfer happens on a rising edge where req_valid[i] and
// req_ready[i] are both high; req_ready is only ever offered in IDLE, and a
// requester must hold valid and payload stable until it sees ready.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_control0,
  input  logic [3:0]  req_control1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_b1,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_result,
  output logic [7:0]  rsp_status,
  output logic        busy,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic [7:0]  alu_status,
  output logic [7:0]  sticky_status,
  input  logic        sticky_clr
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_grant_id;

  logic [1:0]  w_grant;
  logic        w_fire;
  logic        w_sel;
  logic [3:0]  w_ctl;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_capture;
  logic [7:0]  w_sticky_base;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (req_valid),
    .i_enable (r_state == IDLE),
    .o_grant  (w_grant)
  );

  assign req_ready = (r_state == IDLE) ? w_grant : 2'b00;
  assign busy      = (r_state == BUSY);

  // Grants only exist for valid requesters, so any ready bit is a transfer.
  assign w_fire = |req_ready;
  assign w_sel  = req_ready[1];
  assign w_ctl  = w_sel ? req_control1 : req_control0;
  assign w_a    = w_sel ? req_a1 : req_a0;
  assign w_b    = w_sel ? req_b1 : req_b0;

  assign w_capture     = (r_state == BUSY) && (r_cnt == '0);
  assign w_sticky_base = sticky_clr ? 8'h00 : sticky_status;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_grant_id    <= 1'b0;
      rsp_valid     <= 2'b00;
      rsp_result    <= 32'd0;
      rsp_status    <= 8'd0;
      sticky_status <= 8'd0;
      alu_control   <= CTRL_RESET;
      alu_a         <= 32'd0;
      alu_b         <= 32'd0;
    end else begin
      rsp_valid <= 2'b00;

      // A clear coinciding with a capture still keeps the newly captured bits.
      if (w_capture) begin
        sticky_status <= w_sticky_base | (alu_status & STICKY_MASK);
      end else if (sticky_clr) begin
        sticky_status <= 8'h00;
      end

      case (r_state)
        IDLE: begin
          if (w_fire) begin
            alu_control <= w_ctl;
            alu_a       <= w_a;
            alu_b       <= w_b;
            r_grant_id  <= w_sel;
            r_cnt       <= op_cycles(w_ctl, MUL_CYCLES, DIV_CYCLES) - CNT_W'(1);
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            rsp_result <= alu_result;
            rsp_status <= alu_status;
            rsp_valid  <= r_grant_id ? 2'b10 : 2'b01;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
